// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
//   state_t   : FSM states, FETCH through ILLEGAL
//   OP_*      : instruction[31:26] opcodes recognised by the decoder
//   ALUSRCB_*, PCSRC_*, ALUOP_* : datapath mux / ALU operation encodings
//   ctrl_t    : bundle of every strobe the FSM drives
//   decode_next() : DECODE-state dispatch on opcode
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    RWB,
    ADDIEX,
    ADDIWB,
    BRANCH,
    JUMP,
    HALTED,
    ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       halted;
    logic       illegal_op;
  } ctrl_t;

  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = EXEC;
      OP_LW, OP_SW: nxt = MEMADR;
      OP_BEQ:       nxt = BRANCH;
      OP_J:         nxt = JUMP;
      OP_ADDI:      nxt = ADDIEX;
      default:      nxt = ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_perf_counter.sv
// Retired-instruction and active-cycle counters for the multi-cycle core.
//   clk, rst    : clock, synchronous active-high reset (clears both counters)
//   inc_retire  : add one to retire_cnt this cycle
//   inc_cycle   : add one to cycle_cnt this cycle
//   retire_cnt, cycle_cnt : CNT_W-bit counts, wrapping modulo 2^CNT_W
module mips_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_retire,
  input  logic             inc_cycle,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic [CNT_W-1:0] r_retire;
  logic [CNT_W-1:0] r_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire <= '0;
      r_cycle  <= '0;
    end else begin
      if (inc_retire) r_retire <= r_retire + CNT_W'(1);
      if (inc_cycle)  r_cycle  <= r_cycle + CNT_W'(1);
    end
  end

  assign retire_cnt = r_retire;
  assign cycle_cnt  = r_cycle;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the 32b MIPS core. Sequences PC, IR, register
// file, ALU and a shared instruction/data memory over several cycles.
//   clk, rst      : clock, synchronous active-high reset
//   opcode        : instruction[31:26] from the IR
//   mem_ready     : memory access completes this cycle
//   halt_req      : stop at the next instruction boundary
//   pc_write .. alu_op : datapath strobes and mux selects
//   instr_done    : pulse in the last cycle of each instruction
//   halted        : FSM parked in HALTED
//   illegal_op    : FSM stuck in ILLEGAL until reset
//   retire_cnt, cycle_cnt : performance counters
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  import mips_ctrl_pkg::*;

  state_t           r_state;
  state_t           w_next;
  ctrl_t            w_ctl;
  ctrl_t            w_out;
  logic             w_done;
  logic [CNT_W-1:0] w_retire_cnt;
  logic [CNT_W-1:0] w_cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_ctl  = '0;
    w_done = 1'b0;
    w_next = r_state;
    case (r_state)
      FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_FOUR;
        w_ctl.alu_op    = ALUOP_ADD;
        w_ctl.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          w_ctl.ir_write = 1'b1;
          w_ctl.pc_write = 1'b1;
          w_next         = DECODE;
        end
      end
      DECODE: begin
        w_ctl.alu_src_b = ALUSRCB_IMM_SL2;
        w_ctl.alu_op    = ALUOP_ADD;
        w_next          = decode_next(opcode);
      end
      MEMADR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_IMM;
        w_ctl.alu_op    = ALUOP_ADD;
        w_next          = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.iord     = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
        w_done           = 1'b1;
      end
      MEMWR: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.iord      = 1'b1;
        w_done          = mem_ready;
      end
      EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_RT;
        w_ctl.alu_op    = ALUOP_FUNCT;
        w_next          = RWB;
      end
      RWB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.reg_dst   = 1'b1;
        w_done          = 1'b1;
      end
      ADDIEX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ALUSRCB_IMM;
        w_ctl.alu_op    = ALUOP_ADD;
        w_next          = ADDIWB;
      end
      ADDIWB: begin
        w_ctl.reg_write = 1'b1;
        w_done          = 1'b1;
      end
      BRANCH: begin
        w_ctl.alu_src_a     = 1'b1;
        w_ctl.alu_src_b     = ALUSRCB_RT;
        w_ctl.alu_op        = ALUOP_SUB;
        w_ctl.pc_write_cond = 1'b1;
        w_ctl.pc_source     = PCSRC_ALUOUT;
        w_done              = 1'b1;
      end
      JUMP: begin
        w_ctl.pc_write  = 1'b1;
        w_ctl.pc_source = PCSRC_JUMP;
        w_done          = 1'b1;
      end
      HALTED: begin
        w_ctl.halted = 1'b1;
        if (!halt_req) w_next = FETCH;
      end
      ILLEGAL: begin
        w_ctl.illegal_op = 1'b1;
      end
      default: w_next = FETCH;
    endcase
    // halt_req is only looked at on the retiring cycle, so it can never cut
    // an instruction or a pending memory access short.
    if (w_done) w_next = halt_req ? HALTED : FETCH;
    w_ctl.instr_done = w_done;
  end

  // The state register may still hold a mid-instruction state during the
  // first reset cycle; masking here keeps every output quiet while rst=1.
  assign w_out = rst ? '0 : w_ctl;

  assign pc_write      = w_out.pc_write;
  assign pc_write_cond = w_out.pc_write_cond;
  assign pc_source     = w_out.pc_source;
  assign iord          = w_out.iord;
  assign mem_read      = w_out.mem_read;
  assign mem_write     = w_out.mem_write;
  assign ir_write      = w_out.ir_write;
  assign reg_dst       = w_out.reg_dst;
  assign mem_to_reg    = w_out.mem_to_reg;
  assign reg_write     = w_out.reg_write;
  assign alu_src_a     = w_out.alu_src_a;
  assign alu_src_b     = w_out.alu_src_b;
  assign alu_op        = w_out.alu_op;
  assign instr_done    = w_out.instr_done;
  assign halted        = w_out.halted;
  assign illegal_op    = w_out.illegal_op;

  mips_perf_counter #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .inc_retire (w_done),
    .inc_cycle  (r_state != HALTED),
    .retire_cnt (w_retire_cnt),
    .cycle_cnt  (w_cycle_cnt)
  );

  assign retire_cnt = rst ? '0 : w_retire_cnt;
  assign cycle_cnt  = rst ? '0 : w_cycle_cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle stimulus/expected-strobe vectors,
// scoreboard queue of expected outputs and counter values.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic        instr_done, halted, illegal_op;
  logic [31:0] retire_cnt, cycle_cnt;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(
    .CNT_W(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .halt_req      (halt_req),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .retire_cnt    (retire_cnt),
    .cycle_cnt     (cycle_cnt)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       halted;
    logic       illegal_op;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic       halt;
    exp_t       exp;
  } vec_t;

  typedef struct packed {
    exp_t        ctl;
    logic [31:0] retire;
    logic [31:0] cycle;
  } sb_t;

  // Expected strobes for each phase, written straight from the state table.
  localparam exp_t Z      = '0;
  localparam exp_t F_WAIT = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
  localparam exp_t F_RDY  = '{mem_read:1'b1, alu_src_b:2'b01, ir_write:1'b1,
                              pc_write:1'b1, default:'0};
  localparam exp_t DEC    = '{alu_src_b:2'b11, default:'0};
  localparam exp_t MADR   = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam exp_t MRD    = '{mem_read:1'b1, iord:1'b1, default:'0};
  localparam exp_t MWB    = '{reg_write:1'b1, mem_to_reg:1'b1, instr_done:1'b1,
                              default:'0};
  localparam exp_t MWR_W  = '{mem_write:1'b1, iord:1'b1, default:'0};
  localparam exp_t MWR_R  = '{mem_write:1'b1, iord:1'b1, instr_done:1'b1,
                              default:'0};
  localparam exp_t EXE    = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
  localparam exp_t RWBK   = '{reg_write:1'b1, reg_dst:1'b1, instr_done:1'b1,
                              default:'0};
  localparam exp_t AWB    = '{reg_write:1'b1, instr_done:1'b1, default:'0};
  localparam exp_t BRN    = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1,
                              pc_source:2'b01, instr_done:1'b1, default:'0};
  localparam exp_t JMP    = '{pc_write:1'b1, pc_source:2'b10, instr_done:1'b1,
                              default:'0};
  localparam exp_t HLT    = '{halted:1'b1, default:'0};
  localparam exp_t ILL    = '{illegal_op:1'b1, default:'0};

  vec_t        vecs[$];
  sb_t         sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned row_idx  = 0;
  logic [31:0] m_retire = '0;
  logic [31:0] m_cycle  = '0;

  task automatic row(input logic r, input logic [5:0] op, input logic rdy,
                     input logic h, input exp_t e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.halt = h; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s row %0d: got %h want %h", name, row_idx, got, want);
  endtask

  // Drives one cycle of stimulus, queues what the DUT must show this cycle,
  // then samples mid-cycle and compares against the queue head.
  task automatic apply(input vec_t v);
    sb_t  e;
    sb_t  q;
    exp_t got;
    @(negedge clk);
    rst = v.rst; opcode = v.op; mem_ready = v.rdy; halt_req = v.halt;
    e.ctl    = v.exp;
    e.retire = v.rst ? 32'd0 : m_retire;
    e.cycle  = v.rst ? 32'd0 : m_cycle;
    sb.push_back(e);
    if (v.rst) begin
      m_retire = '0;
      m_cycle  = '0;
    end else begin
      if (!v.exp.halted)    m_cycle  = m_cycle + 32'd1;
      if (v.exp.instr_done) m_retire = m_retire + 32'd1;
    end
    #1;
    got = '{pc_write:pc_write, pc_write_cond:pc_write_cond, pc_source:pc_source,
            iord:iord, mem_read:mem_read, mem_write:mem_write, ir_write:ir_write,
            reg_dst:reg_dst, mem_to_reg:mem_to_reg, reg_write:reg_write,
            alu_src_a:alu_src_a, alu_src_b:alu_src_b, alu_op:alu_op,
            instr_done:instr_done, halted:halted, illegal_op:illegal_op};
    q = sb.pop_front();
    check("ctrl",   64'(got),        64'(q.ctl));
    check("retire", 64'(retire_cnt), 64'(q.retire));
    check("cycle",  64'(cycle_cnt),  64'(q.cycle));
    row_idx++;
  endtask

  task automatic go(input logic r, input logic [5:0] op, input logic rdy,
                    input logic h, input exp_t e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.halt = h; v.exp = e;
    apply(v);
  endtask

  initial begin
    // Reset, then R-type with zero wait: retire=1, cycle=4 on the next row.
    row(1, 6'h00, 0, 0, Z);     row(1, 6'h00, 0, 0, Z);
    row(0, 6'h00, 1, 0, F_RDY); row(0, 6'h00, 1, 0, DEC);
    row(0, 6'h00, 1, 0, EXE);   row(0, 6'h00, 1, 0, RWBK);
    // lw with two wait cycles in MEMRD: MEMWB lands on cycle 7.
    row(0, 6'h23, 1, 0, F_RDY); row(0, 6'h23, 1, 0, DEC);
    row(0, 6'h23, 1, 0, MADR);  row(0, 6'h23, 0, 0, MRD);
    row(0, 6'h23, 0, 0, MRD);   row(0, 6'h23, 1, 0, MRD);
    row(0, 6'h23, 1, 0, MWB);
    // beq then j, each 3 cycles.
    row(0, 6'h04, 1, 0, F_RDY); row(0, 6'h04, 1, 0, DEC);
    row(0, 6'h04, 0, 0, BRN);
    row(0, 6'h02, 1, 0, F_RDY); row(0, 6'h02, 1, 0, DEC);
    row(0, 6'h02, 0, 0, JMP);
    // Fetch wait (halt_req ignored outside Done), then addi.
    row(0, 6'h08, 0, 1, F_WAIT); row(0, 6'h08, 1, 0, F_RDY);
    row(0, 6'h08, 1, 0, DEC);    row(0, 6'h08, 1, 0, MADR);
    row(0, 6'h08, 1, 0, AWB);
    // sw with one write wait.
    row(0, 6'h2B, 1, 0, F_RDY); row(0, 6'h2B, 1, 0, DEC);
    row(0, 6'h2B, 1, 0, MADR);  row(0, 6'h2B, 0, 0, MWR_W);
    row(0, 6'h2B, 1, 0, MWR_R);
    // Reset for two cycles while lw sits in MEMRD.
    row(0, 6'h23, 1, 0, F_RDY); row(0, 6'h23, 1, 0, DEC);
    row(0, 6'h23, 1, 0, MADR);  row(0, 6'h23, 0, 0, MRD);
    row(1, 6'h23, 0, 0, Z);     row(1, 6'h23, 1, 0, Z);
    row(0, 6'h23, 0, 0, F_WAIT); row(0, 6'h23, 1, 0, F_RDY);

    foreach (vecs[i]) apply(vecs[i]);

    // That fetch saw lw: finish it, then halt on a sw boundary.
    go(0, 6'h23, 1, 0, DEC);  go(0, 6'h23, 1, 0, MADR);
    go(0, 6'h23, 1, 0, MRD);  go(0, 6'h23, 1, 0, MWB);
    go(0, 6'h2B, 1, 0, F_RDY); go(0, 6'h2B, 1, 1, DEC);
    go(0, 6'h2B, 1, 1, MADR);  go(0, 6'h2B, 0, 1, MWR_W);
    go(0, 6'h2B, 1, 1, MWR_R);
    for (int i = 0; i < 3; i++) go(0, 6'h2B, 1, 1, HLT);
    go(0, 6'h2B, 1, 0, HLT);
    go(0, 6'h00, 1, 0, F_RDY);

    // Illegal opcode: sticky, ignores halt_req and mem_ready, only reset exits.
    go(0, 6'h3F, 1, 0, DEC);
    for (int i = 0; i < 12; i++) go(0, 6'h3F, i[0], i[1], ILL);
    go(1, 6'h3F, 1, 0, Z);
    go(0, 6'h00, 1, 0, F_RDY); go(0, 6'h00, 1, 0, DEC);
    go(0, 6'h00, 1, 0, EXE);   go(0, 6'h00, 1, 0, RWBK);
    go(0, 6'h00, 0, 0, F_WAIT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
